// File: rtl/reverser.sv
// rtl/reverser.sv - registered 2**N-bit bit-order reverser built from gated butterfly stages
module reverser #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [(2**N)-1:0] x,
    input  logic              s,
    input  logic              in_valid,
    output logic [(2**N)-1:0] out,
    output logic              out_valid
);
    localparam int W = 2 ** N;

    logic [N:0][W-1:0] stage_w;
    logic [W-1:0]      out_d, out_q;
    logic              out_valid_d, out_valid_q;

    assign stage_w[0] = x;

    // Stage j swaps adjacent 2**k-bit blocks (k = N-1-j); the XOR of all stage
    // strides is W-1, so the cascade lands every bit on its mirrored index.
    for (genvar j = 0; j < N; j++) begin : g_stage
        localparam int K = N - 1 - j;
        for (genvar i = 0; i < W; i++) begin : g_bit
            localparam int P = i ^ (1 << K);
            assign stage_w[j+1][i] = s ? stage_w[j][P] : stage_w[j][i];
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = stage_w[N];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_reverser.sv
// tb/tb_reverser.sv - scoreboard bench for reverser at N=3 with N=2 and N=4 companions
module tb_reverser;
    logic        clk;
    logic        reset;
    logic [7:0]  x;
    logic        s;
    logic        in_valid;
    logic [7:0]  out8;
    logic        out_valid8;
    logic [3:0]  x4, out4;
    logic        out_valid4;
    logic [15:0] x16, out16;
    logic        out_valid16;

    assign x4  = x[3:0];
    assign x16 = {8'h00, x};

    reverser #(.N(3)) dut8 (
        .clk(clk), .reset(reset), .x(x), .s(s), .in_valid(in_valid),
        .out(out8), .out_valid(out_valid8)
    );
    reverser #(.N(2)) dut4 (
        .clk(clk), .reset(reset), .x(x4), .s(s), .in_valid(in_valid),
        .out(out4), .out_valid(out_valid4)
    );
    reverser #(.N(4)) dut16 (
        .clk(clk), .reset(reset), .x(x16), .s(s), .in_valid(in_valid),
        .out(out16), .out_valid(out_valid16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0]  q8[$];
    logic [3:0]  q4[$];
    logic [15:0] q16[$];
    int          tests  = 0;
    int          failed = 0;
    logic [7:0]  hold8  = 8'h00;
    logic        reset_seen = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mirror(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = v[w-1-i];
        return r;
    endfunction

    always @(posedge clk) reset_seen = reset;

    always @(negedge clk) begin
        if (reset_seen) begin
            chk("reset_out", {8'h00, out8}, 16'h0000);
            chk("reset_valid", {15'h0, out_valid8}, 16'h0000);
            hold8 = 8'h00;
        end else if (out_valid8) begin
            if (q8.size() == 0) chk("spurious_valid", 16'h0001, 16'h0000);
            else begin
                hold8 = q8.pop_front();
                chk("out8", {8'h00, out8}, {8'h00, hold8});
            end
            if (q4.size() == 0 || !out_valid4) chk("valid4", {15'h0, out_valid4}, 16'h0000);
            else chk("out4", {12'h0, out4}, {12'h0, q4.pop_front()});
            if (q16.size() == 0 || !out_valid16) chk("valid16", {15'h0, out_valid16}, 16'h0000);
            else chk("out16", out16, q16.pop_front());
        end else begin
            chk("idle_hold", {8'h00, out8}, {8'h00, hold8});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] xv, input logic sv,
                        input logic [7:0] e8, input logic [3:0] e4, input logic [15:0] e16);
        x = xv; s = sv; in_valid = 1'b1;
        q8.push_back(e8); q4.push_back(e4); q16.push_back(e16);
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        x = 8'hxx;
        s = 1'bx;
        repeat (n) tick();
    endtask

    initial begin
        logic [7:0] rx;
        logic       rs;
        reset = 1'b1; x = 8'h00; s = 1'b0; in_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        idle(1);

        send(8'hF0, 1'b0, 8'hF0, 4'h0, 16'h00F0);
        idle(1);
        send(8'hF0, 1'b1, 8'h0F, 4'h0, 16'h0F00);
        idle(1);

        send(8'h82, 1'b1, 8'h41, 4'h4, 16'h4100);
        send(8'h01, 1'b1, 8'h80, 4'h8, 16'h8000);
        send(8'hA5, 1'b1, 8'hA5, 4'hA, 16'hA500);
        send(8'h81, 1'b0, 8'h81, 4'h1, 16'h0081);
        idle(1);

        send(8'h03, 1'b1, 8'hC0, 4'hC, 16'hC000);
        send(8'h81, 1'b1, 8'h81, 4'h8, 16'h8100);
        send(8'hFF, 1'b1, 8'hFF, 4'hF, 16'hFF00);
        send(8'h00, 1'b1, 8'h00, 4'h0, 16'h0000);
        send(8'h2D, 1'b1, 8'hB4, 4'hB, 16'hB400);
        send(8'hB4, 1'b1, 8'h2D, 4'h2, 16'h2D00);
        idle(2);

        reset = 1'b1; x = 8'h3C; s = 1'b1; in_valid = 1'b1;
        tick();
        reset = 1'b0;
        idle(2);

        for (int c = 0; c < 1000; c++) begin
            rx = 8'($urandom);
            rs = 1'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                logic [15:0] m8, m4, m16;
                m8  = rs ? mirror({8'h00, rx}, 8) : {8'h00, rx};
                m4  = rs ? mirror({12'h0, rx[3:0]}, 4) : {12'h0, rx[3:0]};
                m16 = rs ? mirror({8'h00, rx}, 16) : {8'h00, rx};
                send(rx, rs, m8[7:0], m4[3:0], m16);
            end else begin
                idle(1);
            end
        end
        idle(3);

        chk("drain8", 16'(q8.size()), 16'h0000);
        chk("drain4", 16'(q4.size()), 16'h0000);
        chk("drain16", 16'(q16.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/reverser.md
Name: reverser

Overview:
- Parameterised bit-order reverser on a 2**N-bit word.
- When select `s` is high, the registered output is `x` with bit order mirrored (MSB↔LSB); when low, `x` passes through unchanged.
- Used as a datapath utility (endianness or bit-order correction) between registered stages.
- One clock, one cycle latency, simple valid strobe.

Parameters:
- N, 3, log2 of the data width; data width W = 2**N (default 8 bits). Legal range 1..6.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- x  input  W  data word to process.
- s  input  1  mode select: 0 = pass-through, 1 = bit reverse.
- in_valid  input  1  high when x/s carry a word to be captured this cycle.
- out  output  W  registered result.
- out_valid  output  1  high for one cycle per captured word.

Behaviour:
- Reset (reset=1 at a rising edge):
  - out <= 0, out_valid <= 0.
  - Reset dominates in_valid in the same cycle.
  - Reset asserted mid-stream discards the in-flight word.
- Capture, on a rising edge with reset=0 and in_valid=1:
  - s=0: out <= x.
  - s=1: out[i] <= x[W-1-i] for all i in 0..W-1.
  - out_valid <= 1.
- Latency: exactly 1 clock from x/s/in_valid sampled to out/out_valid visible. Back-to-back words every cycle are supported (throughput 1 word/clock).
- Idle, on a rising edge with reset=0 and in_valid=0:
  - out holds its previous value.
  - out_valid <= 0.
- s is sampled only together with x; no mode state is retained between words.
- Reversal network:
  - Built as N butterfly stages. Stage k (k = N-1 down to 0) swaps adjacent blocks of 2**k bits, gated by s.
  - The result must equal the direct index mirror for every W.
  - The network is purely combinational between the input and the output register; no extra pipeline registers.
- Boundary cases:
  - Palindromic words (e.g. 8'h81, 8'hFF, 8'h00) give identical results for s=0 and s=1.
  - Reverse is an involution: feeding `out` back in with s=1 reproduces the original x.
- No X propagation from out when in_valid=0. Inputs are don't-care while idle.

Test Plan:
- Reset, then x=8'b1111_0000, s=0, in_valid=1 for one cycle -> next cycle out=8'hF0, out_valid=1; the following idle cycle out_valid=0, out stays 8'hF0.
- Same x, s=1, in_valid=1 -> next cycle out=8'h0F, out_valid=1.
- Streaming with s=1: 8'h82, 8'h01, 8'hA5, then 8'h81 with s=0, one per cycle -> out=8'h41, 8'h80, 8'hA5, 8'h81 on consecutive cycles with out_valid continuously 1.
- Reset asserted in the same cycle as in_valid=1 (x=8'h3C, s=1) -> out=0, out_valid=0 next cycle; the word is not delivered.
- Parameter sweep with N=2 (W=4), x=4'b0011, s=1 -> out=4'b1100. With N=4, x=16'h0001, s=1 -> out=16'h8000.
- Random self-check for 1000 cycles against a reference model (mirror when s=1, else identity, 1-cycle delay, hold when idle) -> zero mismatches.
